// File: rtl/dev_timer_if.sv
// dev_timer_if: MEM-stage data-access bus as seen by a memory-mapped device.
//   addr   - byte address from the MEM stage
//   byteen - per-byte write enables; nonzero = write, 0 = read/idle
//   wdata  - write data, already lane-shifted by the initiator
//   rdata  - read data for the word at addr, returned in the same cycle
// master: the MEM stage / bridge side. slave: the device side.
interface dev_timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/dev_timer.sv
// dev_timer: memory-mapped countdown timer with a level interrupt request.
//
// Register window (16 bytes at BASE_ADDR, BASE_ADDR[3:0] must be zero):
//   index 0 CTRL   : [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload,
//                    1x behaves as one-shot), [3] IM; other bits read 0
//   index 1 PRESET : 32-bit reload value
//   index 2 COUNT  : 32-bit current count, read-only
//   index 3        : reads 0, or STATUS when DEV_TIMER_STAT_EN is defined:
//                    [0] irq_flag, [2:1] state, [15:8] saturating expiry count
//
// Optional build macro: DEV_TIMER_STAT_EN enables the STATUS register and
// the expiry counter behind it.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - dev_timer_if slave modport (addr, byteen, wdata, rdata)
//   irq   - level interrupt request, irq_flag gated by CTRL.IM
module dev_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic       clk,
  input  logic       reset,
  dev_timer_if.slave bus,
  output logic       irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_PRESET = 2'd1;
  localparam logic [1:0] IDX_COUNT  = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
`ifdef DEV_TIMER_STAT_EN
  logic [7:0]  exp_cnt_q, exp_cnt_d;
`endif

  logic        hit;
  logic        wr;
  logic        wr_cfg;
  logic [1:0]  idx;
  logic [31:0] ctrl_wr;
  logic [31:0] preset_wr;
  logic        unused_bits;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode and byte-merged candidate values for the writable registers.
  always_comb begin
    hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    idx       = bus.addr[3:2];
    wr        = hit && (bus.byteen != 4'b0000);
    wr_cfg    = wr && ((idx == IDX_CTRL) || (idx == IDX_PRESET));
    ctrl_wr   = merge_bytes({28'd0, ctrl_q}, bus.wdata, bus.byteen);
    preset_wr = merge_bytes(preset_q, bus.wdata, bus.byteen);
  end

  // Word-aligned addressing and CTRL's unimplemented upper bits are dropped.
  assign unused_bits = ^{bus.addr[1:0], ctrl_wr[31:4]};

  // Next-state logic. A CTRL/PRESET write overrides whatever the state
  // machine would have done this cycle, including a pending expiry, and
  // restarts from IDLE so the new settings take effect cleanly.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
`ifdef DEV_TIMER_STAT_EN
    exp_cnt_d  = exp_cnt_q;
`endif

    if (wr_cfg) begin
      if (idx == IDX_CTRL) begin
        ctrl_d = ctrl_wr[3:0];
      end else begin
        preset_d = preset_wr;
      end
      state_d    = IDLE;
      irq_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_q[0]) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          count_d = preset_q;
          state_d = CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_d = IDLE;
          end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            // A count of 1 or 0 expires; PRESET=0 therefore fires immediately.
            count_d    = 32'd0;
            irq_flag_d = 1'b1;
            state_d    = INT;
`ifdef DEV_TIMER_STAT_EN
            if (exp_cnt_q != 8'hff) begin
              exp_cnt_d = exp_cnt_q + 8'd1;
            end
`endif
          end
        end
        INT: begin
          // Auto-reload keeps EN so IDLE immediately reloads; the flag lasts
          // one cycle. Any other mode stops and leaves the flag latched.
          if (ctrl_q[2:1] == 2'b01) begin
            irq_flag_d = 1'b0;
          end else begin
            ctrl_d[0] = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

`ifdef DEV_TIMER_STAT_EN
      // A STATUS write clears after the state machine so it beats an expiry
      // landing in the same cycle.
      if (wr && (idx == IDX_STATUS)) begin
        irq_flag_d = 1'b0;
        exp_cnt_d  = 8'd0;
      end
`endif
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
`ifdef DEV_TIMER_STAT_EN
      exp_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef DEV_TIMER_STAT_EN
      exp_cnt_q  <= exp_cnt_d;
`endif
    end
  end

  // Zero-latency read mux; reads see the values before any same-cycle write.
  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      unique case (idx)
        IDX_CTRL:   bus.rdata = {28'd0, ctrl_q};
        IDX_PRESET: bus.rdata = preset_q;
        IDX_COUNT:  bus.rdata = count_q;
        IDX_STATUS: begin
`ifdef DEV_TIMER_STAT_EN
          bus.rdata = {16'd0, exp_cnt_q, 5'd0, state_q, irq_flag_q};
`else
          bus.rdata = 32'd0;
`endif
        end
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule
